// File: rtl/image_frame_sequencer_pkg.sv
// Shared types and helpers for the image frame sequencer: FSM state encoding,
// Fletcher modulus and the host word-order byte swaps.
package image_frame_sequencer_pkg;

    localparam int FletcherModulus = 65535;

    typedef logic [15:0] word_t;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StHeader = 3'd1,
        StPixels = 3'd2,
        StCksum0 = 3'd3,
        StCksum1 = 3'd4,
        StPad    = 3'd5,
        StDone   = 3'd6
    } seqState_e;

    function automatic word_t swap16(input word_t w);
        return {w[7:0], w[15:8]};
    endfunction

    // Host order of the checksum: low half first, each half byte-swapped.
    function automatic logic [31:0] swap32(input logic [31:0] c);
        return {c[7:0], c[15:8], c[23:16], c[31:24]};
    endfunction

endpackage

// File: rtl/image_frame_sequencer_if.sv
// Pixel input and framed output stream handshakes of the sequencer.
interface image_frame_sequencer_if;
    import image_frame_sequencer_pkg::*;

    logic  in_valid;
    logic  in_ready;
    word_t in_data;
    logic  out_valid;
    logic  out_ready;
    word_t out_data;

    modport master (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport slave (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

endinterface

// File: rtl/image_frame_sequencer_fletcher32_accum.sv
// Fletcher-32 running accumulator over 16-bit host words; dout = {b, a}.
module fletcher32_accum
    import image_frame_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [15:0] din,
    output logic [31:0] dout
);

    logic [15:0] sumA;
    logic [15:0] sumB;
    logic [15:0] sumANext;

    // Single conditional subtract, so 0xFFFF folds to 0.
    function automatic logic [15:0] modAdd(input logic [15:0] x, input logic [15:0] y);
        logic [16:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= 17'(FletcherModulus)) s = s - 17'(FletcherModulus);
        return s[15:0];
    endfunction

    always_comb sumANext = modAdd(sumA, din);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sumA <= '0;
            sumB <= '0;
        end else if (clr) begin
            sumA <= '0;
            sumB <= '0;
        end else if (en) begin
            sumA <= sumANext;
            sumB <= modAdd(sumB, sumANext);
        end
    end

    assign dout = {sumB, sumA};

endmodule

// File: rtl/image_frame_sequencer.sv
// Frames one image: header words, (thumbnail-filtered) pixels, Fletcher-32
// checksum and zero padding, as a single valid/ready output stream.
module image_frame_sequencer
    import image_frame_sequencer_pkg::*;
#(
    parameter int HeaderWordCount = 8,
    parameter int DimWidth        = 12
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic [DimWidth-1:0]                cfg_width,
    input  logic [DimWidth-1:0]                cfg_height,
    input  logic [3:0]                         cfg_period,
    input  logic [3:0]                         cfg_keep,
    input  logic [15:0]                        cfg_pad_words,
    output logic [$clog2(HeaderWordCount)-1:0] hdr_idx,
    input  logic [15:0]                        hdr_data,
    image_frame_sequencer_if.master            io,
    output logic                               busy,
    output logic                               done
);

    localparam int HdrIdxW = $clog2(HeaderWordCount);

    localparam logic [2:0] IDLE   = StIdle;
    localparam logic [2:0] HEADER = StHeader;
    localparam logic [2:0] PIXELS = StPixels;
    localparam logic [2:0] CKSUM0 = StCksum0;
    localparam logic [2:0] CKSUM1 = StCksum1;
    localparam logic [2:0] PAD    = StPad;
    localparam logic [2:0] DONE   = StDone;

    logic [2:0]          state;
    logic [DimWidth-1:0] widthR, heightR, xCnt, yCnt;
    logic [3:0]          periodR, keepR, xPhase, yPhase;
    logic [15:0]         padR, padCnt;
    logic [HdrIdxW-1:0]  hdrIdx;
    logic [31:0]         cksum, cksumHost;
    logic [15:0]         outData;
    logic                outValid, inReady, outHs, inHs, keepPix, lastPix, lastCol;

    assign cksumHost = swap32(cksum);
    assign keepPix   = (xPhase < keepR) && (yPhase < keepR);
    assign lastCol   = (xCnt == widthR - DimWidth'(1));
    assign lastPix   = lastCol && (yCnt == heightR - DimWidth'(1));

    always_comb begin
        outValid = 1'b0;
        inReady  = 1'b0;
        outData  = '0;
        case (state)
            HEADER: begin
                outValid = 1'b1;
                outData  = hdr_data;
            end
            PIXELS: begin
                // Dropped pixels are swallowed without touching the output.
                if (keepPix) begin
                    outValid = io.in_valid;
                    inReady  = io.out_ready;
                    outData  = io.in_data;
                end else begin
                    inReady = 1'b1;
                end
            end
            CKSUM0: begin
                outValid = 1'b1;
                outData  = cksumHost[31:16];
            end
            CKSUM1: begin
                outValid = 1'b1;
                outData  = cksumHost[15:0];
            end
            PAD:     outValid = 1'b1;
            default: ;
        endcase
    end

    assign outHs = outValid && io.out_ready;
    assign inHs  = io.in_valid && inReady;

    fletcher32_accum uAccum (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (start && (state == IDLE)),
        .en   (outHs && ((state == HEADER) || (state == PIXELS))),
        .din  (swap16(outData)),
        .dout (cksum)
    );

    always_ff @(posedge clk) begin
        if ((state == IDLE) && start) begin
            widthR  <= cfg_width;
            heightR <= cfg_height;
            periodR <= cfg_period;
            keepR   <= cfg_keep;
            padR    <= cfg_pad_words;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            hdrIdx <= '0;
            xCnt   <= '0;
            yCnt   <= '0;
            xPhase <= '0;
            yPhase <= '0;
            padCnt <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    hdrIdx <= '0;
                    xCnt   <= '0;
                    yCnt   <= '0;
                    xPhase <= '0;
                    yPhase <= '0;
                    state  <= HEADER;
                end
                HEADER: if (outHs) begin
                    if (hdrIdx == HdrIdxW'(HeaderWordCount - 1)) begin
                        hdrIdx <= '0;
                        state  <= PIXELS;
                    end else begin
                        hdrIdx <= hdrIdx + HdrIdxW'(1);
                    end
                end
                PIXELS: if (inHs) begin
                    if (lastPix) state <= CKSUM0;
                    if (lastCol) begin
                        xCnt   <= '0;
                        xPhase <= '0;
                        yCnt   <= yCnt + DimWidth'(1);
                        yPhase <= (yPhase == periodR - 4'd1) ? 4'd0 : yPhase + 4'd1;
                    end else begin
                        xCnt   <= xCnt + DimWidth'(1);
                        xPhase <= (xPhase == periodR - 4'd1) ? 4'd0 : xPhase + 4'd1;
                    end
                end
                CKSUM0: if (outHs) state <= CKSUM1;
                CKSUM1: if (outHs) begin
                    padCnt <= '0;
                    state  <= (padR == 16'd0) ? DONE : PAD;
                end
                PAD: if (outHs) begin
                    if (padCnt == padR - 16'd1) state <= DONE;
                    else padCnt <= padCnt + 16'd1;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign io.out_valid = outValid;
    assign io.out_data  = outData;
    assign io.in_ready  = inReady;
    assign hdr_idx      = hdrIdx;
    assign busy         = (state != IDLE);
    assign done         = (state == DONE);

endmodule

// File: tb/tb_image_frame_sequencer.sv
// Directed bench for image_frame_sequencer: a frame-level model predicts every
// output word; a monitor checks each output handshake, stalls and done timing.
module tb_image_frame_sequencer;
    import image_frame_sequencer_pkg::*;

    localparam int HW = 2;
    localparam int DW = 12;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   start = 1'b0;
    logic [DW-1:0]          cfg_width = '0, cfg_height = '0;
    logic [3:0]             cfg_period = 4'd1, cfg_keep = 4'd1;
    logic [15:0]            cfg_pad_words = '0;
    logic [$clog2(HW)-1:0]  hdr_idx;
    logic [15:0]            hdr_data;
    logic                   busy, done;
    logic [15:0]            hdrMem [HW];

    image_frame_sequencer_if io();

    assign hdr_data = hdrMem[hdr_idx];

    image_frame_sequencer #(.HeaderWordCount(HW), .DimWidth(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_width(cfg_width), .cfg_height(cfg_height),
        .cfg_period(cfg_period), .cfg_keep(cfg_keep), .cfg_pad_words(cfg_pad_words),
        .hdr_idx(hdr_idx), .hdr_data(hdr_data), .io(io),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    logic [15:0] inQ[$], expQ[$], gotQ[$];
    int  inAccepted = 0;
    bit  randReady = 1'b0;
    bit  monEn = 1'b0;

    function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h (t=%0t)", nm, got, exp, $time);
        end
    endfunction

    // Pixel source and output-ready driver.
    initial begin
        bit hs;
        io.in_valid  = 1'b0;
        io.in_data   = '0;
        io.out_ready = 1'b1;
        forever begin
            @(negedge clk);
            hs = io.in_valid && io.in_ready;
            @(posedge clk);
            #1;
            if (hs && inQ.size() > 0) begin
                void'(inQ.pop_front());
                inAccepted++;
            end
            io.in_valid  = (inQ.size() > 0);
            io.in_data   = (inQ.size() > 0) ? inQ[0] : 16'h0;
            io.out_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor.
    initial begin
        bit          stalled;
        logic [15:0] stallData;
        int          lastHs;
        stalled = 1'b0;
        stallData = '0;
        lastHs = -10;
        forever begin
            @(negedge clk);
            if (!rst_n || !monEn) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    chk("stall_hold_data", io.out_data, stallData);
                    chk("stall_hold_valid", io.out_valid, 1);
                end
                if (io.out_valid && io.out_ready) begin
                    gotQ.push_back(io.out_data);
                    if (expQ.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL extra_word got=%0h want=none", io.out_data);
                    end else begin
                        chk("word", io.out_data, expQ.pop_front());
                    end
                    lastHs = cyc;
                end
                stalled   = io.out_valid && !io.out_ready;
                stallData = io.out_data;
                if (done) chk("done_after_last_hs", cyc, lastHs + 1);
            end
        end
    end

    // Frame-level model: fills expQ and the pixel source, returns checksum C.
    task automatic startFrame(input int w, input int h, input int per, input int kp,
                              input int pad, input int mode, output logic [31:0] c);
        int a, b, v, host;
        a = 0;
        b = 0;
        @(posedge clk);
        #1;
        gotQ.delete();
        expQ.delete();
        inQ.delete();
        inAccepted = 0;
        for (int j = 0; j < HW; j++) begin
            v = int'(hdrMem[j]);
            expQ.push_back(16'(v));
            host = ((v & 255) << 8) | (v >> 8);
            a = (a + host) % 65535;
            b = (b + a) % 65535;
        end
        for (int i = 0; i < w * h; i++) begin
            v = (mode == 0) ? ((i + 3) << 8) : (mode == 1) ? i : 65535;
            inQ.push_back(16'(v));
            if (((i % w) % per) < kp && ((i / w) % per) < kp) begin
                expQ.push_back(16'(v));
                host = ((v & 255) << 8) | (v >> 8);
                a = (a + host) % 65535;
                b = (b + a) % 65535;
            end
        end
        c = {16'(b), 16'(a)};
        expQ.push_back({c[7:0], c[15:8]});
        expQ.push_back({c[23:16], c[31:24]});
        for (int p = 0; p < pad; p++) expQ.push_back(16'h0000);
        cfg_width     = DW'(w);
        cfg_height    = DW'(h);
        cfg_period    = 4'(per);
        cfg_keep      = 4'(kp);
        cfg_pad_words = 16'(pad);
        start         = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input int w, input int h);
        int n;
        n = 0;
        while (!done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", done, 1);
        chk("exp_words_left", expQ.size(), 0);
        chk("pixels_accepted", inAccepted, w * h);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
    endtask

    initial begin
        logic [31:0] c;
        int n;
        hdrMem[0] = 16'h0100;
        hdrMem[1] = 16'h0200;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", io.out_valid, 0);
        chk("rst_in_ready", io.in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hdr_idx", hdr_idx, 0);
        chk("rst_out_data", io.out_data, 0);
        monEn = 1'b1;

        // In-order, no filtering.
        startFrame(4, 2, 1, 1, 3, 0, c);
        chk("model_cksum_s1", c, 32'h00DC0037);
        @(negedge clk);
        chk("first_hdr_valid", io.out_valid, 1);
        chk("busy_in_frame", busy, 1);
        waitDone(4, 2);
        chk("s1_len", gotQ.size(), 15);
        if (gotQ.size() == 15) begin
            chk("s1_w0", gotQ[10], 16'h3700);
            chk("s1_w1", gotQ[11], 16'hDC00);
            chk("s1_pad", {gotQ[12], gotQ[13], gotQ[14]}, 32'h0);
        end

        // Thumbnail filtering.
        startFrame(4, 4, 2, 1, 0, 1, c);
        waitDone(4, 4);
        chk("s2_len", gotQ.size(), 8);
        if (gotQ.size() == 8) begin
            chk("s2_px0", gotQ[2], 16'd0);
            chk("s2_px1", gotQ[3], 16'd2);
            chk("s2_px2", gotQ[4], 16'd8);
            chk("s2_px3", gotQ[5], 16'd10);
        end

        // Backpressure on the first scenario.
        randReady = 1'b1;
        startFrame(4, 2, 1, 1, 3, 0, c);
        waitDone(4, 2);
        randReady = 1'b0;
        chk("bp_len", gotQ.size(), 15);
        if (gotQ.size() == 15) begin
            chk("bp_w0", gotQ[10], 16'h3700);
            chk("bp_w1", gotQ[11], 16'hDC00);
        end

        // Modular wrap.
        hdrMem[0] = 16'hFFFF;
        hdrMem[1] = 16'hFFFF;
        startFrame(2, 2, 1, 1, 0, 2, c);
        chk("model_cksum_wrap", c, 32'h0);
        waitDone(2, 2);
        if (gotQ.size() == 8) begin
            chk("wrap_w0", gotQ[6], 16'h0000);
            chk("wrap_w1", gotQ[7], 16'h0000);
        end else begin
            chk("wrap_len", gotQ.size(), 8);
        end
        hdrMem[0] = 16'h0100;
        hdrMem[1] = 16'h0200;

        // Start while busy, with zero padding.
        startFrame(4, 2, 1, 1, 0, 0, c);
        repeat (2) @(posedge clk);
        #1;
        cfg_width     = DW'(8);
        cfg_pad_words = 16'd5;
        start         = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        waitDone(4, 2);
        chk("nopad_len", gotQ.size(), 12);
        repeat (3) @(negedge clk);
        chk("busy_start_ignored_busy", busy, 0);
        chk("busy_start_ignored_valid", io.out_valid, 0);

        // Reset mid-PIXELS, then a clean rerun.
        startFrame(4, 2, 1, 1, 3, 0, c);
        n = 0;
        while (inAccepted < 3 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("reached_pixels", inAccepted >= 3, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        monEn = 1'b0;
        #1;
        chk("arst_out_valid", io.out_valid, 0);
        chk("arst_in_ready", io.in_ready, 0);
        chk("arst_busy", busy, 0);
        inQ.delete();
        expQ.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        monEn = 1'b1;
        startFrame(4, 2, 1, 1, 3, 0, c);
        waitDone(4, 2);
        if (gotQ.size() == 15) begin
            chk("rerun_w0", gotQ[10], 16'h3700);
            chk("rerun_w1", gotQ[11], 16'hDC00);
        end else begin
            chk("rerun_len", gotQ.size(), 15);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/image_frame_sequencer.md
# image_frame_sequencer

Synthesizable sequencer that frames one image for storage. It emits a fixed-length header, then the pixel stream (optionally thumbnail-filtered), then a 2-word Fletcher-32 checksum, then zero padding. It sits between the pixel source and the SD write path. Its output word stream is exactly what the host-side reader and the simulation pixel validator expect: header, pixels, checksum, padding.

## Interface
- HeaderWordCount, 8, number of header words emitted before pixels
- DimWidth, 12, width of the image-dimension config fields
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; samples all cfg_* inputs; ignored unless idle
- cfg_width  in  DimWidth  input (full-size) image width in pixels
- cfg_height  in  DimWidth  input image height in pixels
- cfg_period  in  4  thumbnail filter period (1 = no filtering)
- cfg_keep  in  4  pixels kept at the start of each period, in x and in y
- cfg_pad_words  in  16  zero words emitted after the checksum
- hdr_idx  out  $clog2(HeaderWordCount)  index of the header word being requested
- hdr_data  in  16  header word at hdr_idx; combinational read, same cycle
- in_valid / in_ready  in / out  1  pixel input handshake
- in_data  in  16  pixel word, in wire byte order
- out_valid / out_ready  out / in  1  output stream handshake
- out_data  out  16  output word, in wire byte order
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the frame completes

## Operation
- States: IDLE, HEADER, PIXELS, CKSUM0, CKSUM1, PAD, DONE.
- IDLE: start latches config and clears the checksum, then goes to HEADER.
- HEADER: out_data=hdr_data, out_valid=1. On each handshake, hdr_idx increments. After word HeaderWordCount-1, go to PIXELS.
- PIXELS: x/y phase counters run over the input raster. Modulo-period phase counters give keep = (xphase<cfg_keep)&&(yphase<cfg_keep).
  - When keep: out_valid=in_valid, in_ready=out_ready, out_data=in_data.
  - When not keep: in_ready=1, out_valid=0; the pixel is consumed silently.
  - After input pixel cfg_width*cfg_height-1 is consumed, go to CKSUM0.
- CKSUM0 / CKSUM1: emit w0={C[7:0],C[15:8]}, then w1={C[23:16],C[31:24]}, where C is the 32-bit checksum. Then go to PAD, or to DONE if cfg_pad_words=0.
- PAD: emit cfg_pad_words words of 0x0000.
- DONE: done=1 for one cycle, then IDLE.
- Checksum rules:
  - Consumes the host value {out_data[7:0],out_data[15:8]} on every header and kept-pixel handshake only.
  - Per word: a'=(a+d) mod 65535, b'=(b+a') mod 65535, C={b,a}, with a=b=0 at clear.
  - Modular add: compute a 17-bit sum, subtract 65535 once if sum ≥ 65535. Consequently 0xFFFF ≡ 0.
- Config constraints: cfg_width and cfg_height are multiples of cfg_period, and 1 ≤ cfg_keep ≤ cfg_period. Behaviour outside these constraints is undefined.
- Output pixel count = (W·keep/period)·(H·keep/period).

## Timing
- Reset values: out_valid=0, in_ready=0, busy=0, done=0, hdr_idx=0, out_data=0, state IDLE, checksum a=b=0.
- start at cycle N puts the first header word on out_valid/out_data at cycle N+1.
- PIXELS is a combinational pass-through: zero latency, no buffering.
- Stall rule: while out_valid && !out_ready, out_data and state stay stable.
- The checksum register updates on the last pixel handshake, so C is valid in CKSUM0 with no bubble.
- in_ready=0 outside PIXELS.
- A start asserted while busy is ignored.
- Reset assertion mid-frame aborts immediately to reset values. No partial checksum is retained.

## Structure
- Shared package holds the state enum, the FletcherModulus constant (65535), and the checksum word-order helper (byte swap of 16 and 32 bits).
- Sub-module fletcher32_accum: clk, rst_n, clr, en, din[15:0], dout[31:0] (registered).
- Everything else lives in image_frame_sequencer.

## Test plan
- Words-in-order, no filtering:
  - Setup: HeaderWordCount=2, hdr {0x0100,0x0200}; W=4, H=2, period=keep=1; pixels {k,8'h00} for k=3..10; pad=3; out_ready=1.
  - Required: 15 words; checksum words 0x3700, 0xDC00 (C=0x00DC0037); three 0x0000 pads; done pulse one cycle after the last pad handshake.
- Thumbnail filtering:
  - Setup: period=2, keep=1, W=H=4, input pixel i = i.
  - Required: output pixels 0, 2, 8, 10; all 16 inputs are accepted.
- Backpressure:
  - Stimulus: randomized out_ready (~50%) on the first scenario.
  - Required: identical word sequence; out_data unchanged on every stalled cycle.
- Modular wrap:
  - Setup: header words 0xFFFF, four pixels 0xFFFF.
  - Required: checksum words 0x0000, 0x0000.
- Reset mid-PIXELS:
  - Stimulus: pull rst_n low mid-frame.
  - Required: out_valid, in_ready and busy all 0 asynchronously. A fresh rerun of the first scenario then yields 0x3700, 0xDC00.
- Start while busy, and zero padding:
  - Stimulus: pulse start while busy.
  - Required: start has no effect.
  - Stimulus: cfg_pad_words=0.
  - Required: DONE immediately follows the w1 handshake.
